// File: rtl/fetch_pkg.sv
// Shared types and helpers for the prefetching fetch stage.
// Queue entries carry the PC tag alongside the instruction so decode sees both.
package fetch_pkg;

    localparam int unsigned FETCH_PC_MAX_W       = 32;
    localparam int unsigned DEFAULT_RESET_VECTOR = 0;

    // PC field is sized for the widest supported ADDR_W; narrower cores zero-extend.
    typedef struct packed {
        logic [FETCH_PC_MAX_W-1:0] pc;
        logic [31:0]               inst;
    } fetch_entry_t;

    // Little-endian memory word to decode byte order.
    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; the head is read straight from registered storage,
// so a push into an empty queue becomes visible one cycle later.
module fetch_queue #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     sync_rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign do_push = push;
    assign do_pop  = pop && (count_q != '0);

    always_ff @(posedge clk) begin
        if (!sync_rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (sync_rst && !flush && do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_valid = (count_q != '0);
    assign head_data  = mem_q[rd_ptr_q];
    assign count      = count_q;

    // The credit scheme upstream guarantees a free slot for every push.
    push_never_full: assert property (@(posedge clk) disable iff (!sync_rst)
        (push && !flush) |-> (count_q != FULL));

endmodule

// File: rtl/prefetch_fetch_stage.sv
// Fetch stage with a prefetch queue and multiple outstanding imem requests.
// Redirects flush the queue and drop the responses of every request still in flight.
module prefetch_fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W          = 30,
    parameter int unsigned       DEPTH           = 4,
    parameter int unsigned       MAX_OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0] RESET_VECTOR    = ADDR_W'(DEFAULT_RESET_VECTOR),
    parameter bit                BYTE_SWAP       = 1'b1
) (
    input  logic                   clk,
    input  logic                   sync_rst,
    input  logic                   clk_en,
    input  logic                   jmp,
    input  logic [ADDR_W-1:0]      jmp_target,
    output logic                   imem_req,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic                   imem_ready,
    input  logic                   imem_rvalid,
    input  logic [31:0]            imem_rdata,
    output logic                   dec_valid,
    output logic [31:0]            dec_inst,
    output logic [ADDR_W-1:0]      dec_pc,
    input  logic                   dec_ready,
    output logic [$clog2(DEPTH):0] queue_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] MAX_OUT   = CW'(MAX_OUTSTANDING);
    localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, resp_pc_q;
    logic [CW-1:0]     outstanding_q, outstanding_d, discard_q;
    logic [CW-1:0]     count;
    logic              credit_ok, issue, accept, resp, keep, push, pop, flush;
    logic              head_valid;
    fetch_entry_t      push_entry, head_entry;
    logic              unused_head_pc;

    // Every accepted request reserves a queue slot until its response lands.
    assign credit_ok = (({1'b0, count} + {1'b0, outstanding_q}) < DEPTH_LIM);
    assign issue     = sync_rst && clk_en && !jmp && (outstanding_q < MAX_OUT) && credit_ok;
    assign accept    = issue && imem_ready;
    assign resp      = clk_en && imem_rvalid;
    assign keep      = resp && !jmp && (discard_q == '0);
    assign push      = keep;
    assign pop       = clk_en && !jmp && head_valid && dec_ready;
    assign flush     = clk_en && jmp;

    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({accept, resp})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sync_rst) begin
            fetch_pc_q    <= RESET_VECTOR;
            resp_pc_q     <= RESET_VECTOR;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else if (clk_en) begin
            outstanding_q <= outstanding_d;
            if (jmp) begin
                fetch_pc_q <= jmp_target;
                resp_pc_q  <= jmp_target;
                // Whatever is still in flight after this cycle belongs to the old path.
                discard_q  <= outstanding_d;
            end else begin
                if (accept) begin
                    fetch_pc_q <= fetch_pc_q + 1'b1;
                end
                if (keep) begin
                    resp_pc_q <= resp_pc_q + 1'b1;
                end else if (resp) begin
                    discard_q <= discard_q - 1'b1;
                end
            end
        end
    end

    always_comb begin
        push_entry      = '0;
        push_entry.pc   = FETCH_PC_MAX_W'(resp_pc_q);
        push_entry.inst = BYTE_SWAP ? byte_swap32(imem_rdata) : imem_rdata;
    end

    fetch_queue #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .sync_rst   (sync_rst),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .flush      (flush),
        .head_valid (head_valid),
        .head_data  (head_entry),
        .count      (count)
    );

    assign unused_head_pc = ^head_entry.pc;

    assign imem_req    = issue;
    assign imem_addr   = fetch_pc_q;
    assign dec_valid   = head_valid;
    assign dec_inst    = head_entry.inst;
    assign dec_pc      = head_entry.pc[ADDR_W-1:0];
    assign queue_count = count;

    rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (!sync_rst)
        (clk_en && imem_rvalid) |-> (outstanding_q != '0));

    credit_invariant: assert property (@(posedge clk) disable iff (!sync_rst)
        (({1'b0, count} + {1'b0, outstanding_q}) <= DEPTH_LIM));

    discard_within_outstanding: assert property (@(posedge clk) disable iff (!sync_rst)
        (discard_q <= outstanding_q));

endmodule

// File: tb/tb_prefetch_fetch_stage.sv
// Randomised bench: an imem model with variable latency feeds the DUT; a scoreboard of
// expected fetch PCs (program order, reset on redirect) is checked whenever decode pops.
module tb_prefetch_fetch_stage;

    localparam int unsigned AW    = 30;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic          clk = 1'b0;
    logic          sync_rst, clk_en, jmp, imem_ready, imem_rvalid, dec_ready;
    logic [AW-1:0] jmp_target, imem_addr, dec_pc;
    logic [31:0]   imem_rdata, dec_inst;
    logic          imem_req, dec_valid;
    logic [CW-1:0] queue_count;

    always #5 clk = ~clk;

    prefetch_fetch_stage #(
        .ADDR_W          (AW),
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (2),
        .RESET_VECTOR    ('0),
        .BYTE_SWAP       (1'b1)
    ) dut (
        .clk         (clk),
        .sync_rst    (sync_rst),
        .clk_en      (clk_en),
        .jmp         (jmp),
        .jmp_target  (jmp_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .dec_valid   (dec_valid),
        .dec_inst    (dec_inst),
        .dec_pc      (dec_pc),
        .dec_ready   (dec_ready),
        .queue_count (queue_count)
    );

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } pend_t;

    pend_t         pend[$];
    logic [AW-1:0] exp_pc[$];
    logic [AW-1:0] seen_pcs[$];
    logic [AW-1:0] model_pc;
    int            cycle   = 0;
    int            n_total = 0;
    int            n_pass  = 0;
    int            n_pops  = 0;
    int            lat_min = 1;
    int            lat_max = 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    endtask

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        logic [31:0] h;
        if (a == '0) return 32'h1300_0000;
        h = 32'(a) * 32'h9E37_79B1;
        return h ^ 32'h5BD1_E995;
    endfunction

    function automatic logic [31:0] swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Monitor and scoreboard.
    logic          p_hold = 1'b0;
    logic [AW-1:0] p_pc;
    logic [31:0]   p_inst;

    always @(negedge clk) begin
        logic [AW-1:0] e;
        if (cycle > 0) begin
            if (p_hold) begin
                check("head_hold_valid", 64'(dec_valid), 64'(1'b1));
                check("head_hold_pc", 64'(dec_pc), 64'(p_pc));
                check("head_hold_inst", 64'(dec_inst), 64'(p_inst));
            end
            p_hold = sync_rst && !(clk_en && jmp) && dec_valid && !(clk_en && dec_ready);
            p_pc   = dec_pc;
            p_inst = dec_inst;
            check("count_bound", 64'(queue_count <= CW'(DEPTH)), 64'(1'b1));
            if (!sync_rst) begin
                exp_pc.delete();
                seen_pcs.delete();
                model_pc = '0;
            end else if (!clk_en) begin
                check("req_gated_by_clk_en", 64'(imem_req), 64'(1'b0));
            end else if (jmp) begin
                check("req_during_jmp", 64'(imem_req), 64'(1'b0));
                exp_pc.delete();
                seen_pcs.delete();
                model_pc = jmp_target;
            end else begin
                if (imem_req && imem_ready) begin
                    check("imem_addr", 64'(imem_addr), 64'(model_pc));
                    exp_pc.push_back(model_pc);
                    pend.push_back('{addr: imem_addr,
                                     due: cycle + int'($urandom_range(lat_max, lat_min))});
                    model_pc = model_pc + 1'b1;
                end
                if (dec_valid && dec_ready) begin
                    n_pops++;
                    if (exp_pc.size() == 0) begin
                        check("pop_expected", 64'(1'b0), 64'(1'b1));
                    end else begin
                        e = exp_pc.pop_front();
                        check("dec_pc", 64'(dec_pc), 64'(e));
                        check("dec_inst", 64'(dec_inst), 64'(swap(mem_word(e))));
                        seen_pcs.push_back(dec_pc);
                    end
                end
            end
        end
    end

    // One clock of stimulus; the imem model answers in order once a response is due.
    task automatic cyc(input logic rst_n, input logic en, input logic j,
                       input logic [AW-1:0] tgt, input logic rdy, input int rdy_pct);
        @(posedge clk);
        #1;
        cycle++;
        sync_rst    = rst_n;
        clk_en      = en;
        jmp         = j;
        jmp_target  = tgt;
        dec_ready   = rdy;
        imem_ready  = (int'($urandom_range(99, 0)) < rdy_pct);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (!rst_n) begin
            pend.delete();
        end else if (en && pend.size() > 0 && pend[0].due <= cycle) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic check_first_pc(input string name, input logic [AW-1:0] want);
        logic [AW-1:0] got;
        got = (seen_pcs.size() > 0) ? seen_pcs[0] : 'x;
        check(name, 64'(got), 64'(want));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int            p0;
        logic          s_valid;
        logic [AW-1:0] s_pc;
        logic [31:0]   s_inst;
        logic [CW-1:0] s_count;

        sync_rst    = 1'b0;
        clk_en      = 1'b0;
        jmp         = 1'b0;
        jmp_target  = '0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        dec_ready   = 1'b0;

        // Reset and steady zero-wait flow.
        repeat (3) cyc(1'b0, 1'b1, 1'b0, '0, 1'b1, 100);
        settle();
        check("rst_imem_req", 64'(imem_req), 64'(1'b0));
        check("rst_dec_valid", 64'(dec_valid), 64'(1'b0));
        check("rst_count", 64'(queue_count), 64'(0));
        cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 100);
        settle();
        check("first_req", 64'(imem_req), 64'(1'b1));
        check("first_addr", 64'(imem_addr), 64'(0));
        cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 100);
        settle();
        check("latency_not_early", 64'(dec_valid), 64'(1'b0));
        cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 100);
        settle();
        check("latency_valid", 64'(dec_valid), 64'(1'b1));
        check("first_dec_pc", 64'(dec_pc), 64'(0));
        check("first_dec_inst", 64'(dec_inst), 64'(32'h0000_0013));
        p0 = n_pops;
        repeat (20) cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 100);
        settle();
        check("steady_throughput", 64'(n_pops - p0), 64'(20));

        // Backpressure then drain.
        lat_min = 1;
        lat_max = 3;
        repeat (10) cyc(1'b1, 1'b1, 1'b0, '0, 1'b0, 100);
        settle();
        check("bp_count_full", 64'(queue_count), 64'(DEPTH));
        check("bp_req_low", 64'(imem_req), 64'(1'b0));
        p0 = n_pops;
        repeat (20) cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 100);
        settle();
        check("bp_drain_progress", 64'((n_pops - p0) >= 4), 64'(1'b1));

        // Redirect with two requests in flight.
        lat_min = 3;
        lat_max = 3;
        repeat (8) cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 100);
        cyc(1'b1, 1'b1, 1'b1, AW'(32'h100), 1'b1, 100);
        repeat (20) cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 100);
        settle();
        check_first_pc("redirect_first_pc", AW'(32'h100));

        // Jump coinciding with a response, then a second jump next cycle.
        lat_min = 2;
        lat_max = 2;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 100);
            if (pend.size() > 0 && pend[0].due <= cycle + 1) break;
        end
        cyc(1'b1, 1'b1, 1'b1, AW'(32'h180), 1'b1, 100);
        cyc(1'b1, 1'b1, 1'b1, AW'(32'h200), 1'b1, 100);
        repeat (20) cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 100);
        settle();
        check_first_pc("double_jmp_first_pc", AW'(32'h200));

        // PC wrap at the top of the address space.
        lat_min = 1;
        lat_max = 1;
        cyc(1'b1, 1'b1, 1'b1, {AW{1'b1}} - 1'b1, 1'b1, 100);
        repeat (12) cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 100);
        settle();
        check("wrap_len", 64'(seen_pcs.size() >= 4), 64'(1'b1));
        if (seen_pcs.size() >= 4) begin
            check("wrap_pc0", 64'(seen_pcs[0]), 64'({AW{1'b1}} - 1'b1));
            check("wrap_pc1", 64'(seen_pcs[1]), 64'({AW{1'b1}}));
            check("wrap_pc2", 64'(seen_pcs[2]), 64'(0));
            check("wrap_pc3", 64'(seen_pcs[3]), 64'(1));
        end

        // Random traffic with occasional redirects and enable gaps.
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 400; i++) begin
            cyc(1'b1, ($urandom_range(99, 0) < 90), ($urandom_range(99, 0) < 4),
                AW'($urandom), ($urandom_range(99, 0) < 70), 70);
        end

        // Freeze mid-stream, then reset while frozen.
        lat_min = 2;
        lat_max = 2;
        repeat (6) cyc(1'b1, 1'b1, 1'b0, '0, ($urandom_range(1, 0) == 1), 100);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 100);
        settle();
        s_valid = dec_valid;
        s_pc    = dec_pc;
        s_inst  = dec_inst;
        s_count = queue_count;
        repeat (4) cyc(1'b1, 1'b0, 1'b1, AW'(32'h55), 1'b1, 100);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 100);
        settle();
        check("freeze_valid", 64'(dec_valid), 64'(s_valid));
        check("freeze_pc", 64'(dec_pc), 64'(s_pc));
        check("freeze_inst", 64'(dec_inst), 64'(s_inst));
        check("freeze_count", 64'(queue_count), 64'(s_count));
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 100);
        settle();
        check("midrst_imem_req", 64'(imem_req), 64'(1'b0));
        check("midrst_dec_valid", 64'(dec_valid), 64'(1'b0));
        check("midrst_count", 64'(queue_count), 64'(0));
        cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 100);
        settle();
        check("post_rst_req", 64'(imem_req), 64'(1'b1));
        check("post_rst_addr", 64'(imem_addr), 64'(0));
        repeat (10) cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 100);
        settle();
        check_first_pc("post_rst_first_pc", '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/prefetch_fetch_stage.md
Name: prefetch_fetch_stage

Overview:
Parametrised successor to the single-register fetch stage. It decouples instruction memory from decode using a configurable prefetch queue and supports multiple outstanding requests to a variable-latency instruction memory. On a redirect it discards every in-flight and queued instruction. It sits between instruction memory and decode_stage and replaces the PC register plus direct inst_in path.

Parameters:
ADDR_W, 30, word-address width of PC and imem address.
DEPTH, 4, prefetch queue entries; power of 2, at least 2.
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered imem requests; range 1 to DEPTH.
RESET_VECTOR, 0, word address fetched first after reset.
BYTE_SWAP, 1, 1 = byte-reverse imem_rdata into decode order ({b0,b1,b2,b3}); 0 = pass-through.

Ports:
clk  in  1  core clock
sync_rst  in  1  synchronous reset, active-low (0 = reset)
clk_en  in  1  global enable; 0 freezes all state
jmp  in  1  redirect request from execute/memory
jmp_target  in  ADDR_W  redirect word address
imem_req  out  1  request valid
imem_addr  out  ADDR_W  request word address
imem_ready  in  1  memory accepts the request this cycle
imem_rvalid  in  1  response valid; responses return in order
imem_rdata  in  32  response instruction, little-endian
dec_valid  out  1  queue head valid
dec_inst  out  32  head instruction, after optional swap
dec_pc  out  ADDR_W  head word address
dec_ready  in  1  decode consumes the head (0 = pipeline stall)
queue_count  out  $clog2(DEPTH)+1  occupied entries, for debug and perf

Behaviour:
- Reset (sync_rst=0 at the clk edge, regardless of clk_en):
  - fetch_pc=RESET_VECTOR; queue empty; outstanding=0; discard=0.
  - Outputs: imem_req=0, dec_valid=0, queue_count=0. dec_inst and dec_pc are don't-care.
- clk_en=0: no state changes and imem_req=0. The system gates imem with the same enable, so no response arrives while clk_en=0.
- Issue rule: imem_req=1 when clk_en && !jmp && outstanding<MAX_OUTSTANDING && (count+outstanding)<DEPTH. This credit scheme ensures every response has a slot.
  - imem_addr=fetch_pc, combinational from the register.
- Accept: imem_req && imem_ready. Then fetch_pc increments by 1 modulo 2^ADDR_W (wrap to 0) and outstanding increments.
- Response: imem_rvalid decrements outstanding.
  - If discard>0: the data is dropped and discard decrements.
  - Else: push {pc_tag, rdata}. pc_tag comes from a response-PC counter that advances per kept response and is loaded with jmp_target on redirect.
- Pop: dec_valid && dec_ready. Head holds stable while dec_ready=0.
- Latency: minimum imem-accept to dec_valid is imem latency + 1 cycle (queue write, registered head).
- Same-cycle push and pop: count unchanged; a push into an empty queue is not visible until the next cycle (no bypass).
- Redirect (jmp=1 with clk_en=1):
  - Highest priority over issue, push and pop. The queue is flushed (count=0) and dec_valid=0 from the next cycle.
  - fetch_pc and resp_pc are set to jmp_target.
  - discard is set to outstanding_after, where outstanding_after = outstanding + accept − rvalid. The accept term is 0 because imem_req=0 during jmp. A response arriving in the jmp cycle is dropped.
  - Any previous discard value is subsumed: outstanding_after already counts all remaining in-flight requests.
- Back-to-back jmp: each one re-targets; the last one wins. discard stays equal to outstanding.
- After a redirect, issue resumes the next cycle at jmp_target, even while discard>0.
- Invariants: count+outstanding ≤ DEPTH; discard ≤ outstanding. An imem_rvalid with outstanding=0 is a protocol error and is flagged by an assertion.

Decomposition:
- Package fetch_pkg holds:
  - typedef fetch_entry_t {logic [ADDR_W-1:0] pc; logic [31:0] inst;}
  - byte-swap function
  - RESET_VECTOR default constant
- Sub-module fetch_queue: synchronous FIFO with parameters WIDTH and DEPTH, a flush port, a registered head, and a count output.
- The top level holds the PC, outstanding/discard counters and the issue logic.

Test Plan:
- Reset then steady flow: zero-wait imem, dec_ready=1, MAX_OUTSTANDING=2 → dec_pc=0,1,2,3… with one instruction per cycle after fill. 0x13000000 arrives at dec_inst as 0x00000013.
- Backpressure: dec_ready=0 for 10 cycles → queue_count saturates at 4, imem_req=0, and dec_pc/dec_inst hold stable. Release → in-order drain with no loss or duplication.
- Redirect with 2 outstanding (imem latency 3): jmp to 0x100 → both stale responses dropped; the first dec_pc after the redirect is 0x100, and no pre-jmp instruction is seen.
- Jmp coincident with imem_rvalid, then a second jmp one cycle later to 0x200 → only instructions from 0x200 reach decode.
- PC wrap: ADDR_W=4, jmp to 0xE → dec_pc sequence 0xE, 0xF, 0x0, 0x1.
- clk_en=0 for 5 cycles mid-stream, then sync_rst=0 asserted mid-operation → state frozen during the clk_en gap. After reset: imem_req=0, dec_valid=0 and queue_count=0; the first fetch is at RESET_VECTOR.
